uart_frame_loader: RTL

//  Upstream stage between the UART receiver and a word-wide image memory.

---
 rtl/uart_loader_pkg.sv | 15 +
 rtl/uart_byte_ack.sv | 34 +++
 rtl/uart_frame_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types for the UART frame loader: FSM state encoding and word geometry.
package uart_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DRAIN,
    WRITE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/uart_byte_ack.sv
// UART rdy/rdy_clr handshake: takes one byte per rx_rdy assertion and blocks
// recapture until the receiver has dropped rx_rdy.
module uart_byte_ack (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       rx_rdy,
  input  logic [7:0] rx_dout,
  output logic       rx_rdy_clr,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic pending;

  // Capture is combinational so the owner consumes the byte in the cycle it is seen;
  // the acknowledge to the UART is registered.
  assign byte_valid = accept && rx_rdy && !pending;
  assign byte_data  = rx_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= 1'b0;
      rx_rdy_clr <= 1'b0;
    end else begin
      rx_rdy_clr <= byte_valid;
      if (byte_valid)
        pending <= 1'b1;
      else if (!rx_rdy)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Packs UART bytes into 32-bit words and writes one frame of WORDS words.
// Optional trailing checksum byte: define UART_FRAME_LOADER_CSUM_EN.
module uart_frame_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned WORDS       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_dout,
  output logic              rx_rdy_clr,
  output logic [ADDR_W-1:0] wraddress,
  output logic [31:0]       data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              csum_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic [2:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [TW-1:0]     timer;
  logic [31:0]       word;
  logic              accept;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              timer_hit;

  // IDLE keeps accepting so stale bytes are acknowledged and dropped.
  assign accept    = (state == IDLE) || (state == RECV) || (state == CHECK);
  assign timer_hit = (timer == TW'(TIMEOUT_CYC - 1));

  uart_byte_ack u_ack (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .rx_rdy     (rx_rdy),
    .rx_dout    (rx_dout),
    .rx_rdy_clr (rx_rdy_clr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

`ifdef UART_FRAME_LOADER_CSUM_EN
  logic [7:0] sum;
`else
  assign csum_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      timer     <= '0;
      word      <= '0;
      wraddress <= '0;
      data      <= '0;
      wren      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
`ifdef UART_FRAME_LOADER_CSUM_EN
      sum       <= '0;
      csum_err  <= 1'b0;
`endif
    end else begin
      wren    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RECV;
            busy     <= 1'b1;
            word_cnt <= '0;
            byte_cnt <= '0;
            timer    <= '0;
`ifdef UART_FRAME_LOADER_CSUM_EN
            sum      <= '0;
            csum_err <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (byte_valid) begin
            word     <= {word[23:0], byte_data};
            byte_cnt <= byte_cnt + 1'b1;
            timer    <= '0;
            state    <= DRAIN;
`ifdef UART_FRAME_LOADER_CSUM_EN
            sum      <= sum + byte_data;
`endif
          end else if (timer_hit) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRAIN: begin
          if (!rx_rdy)
            state <= (byte_cnt == 3'(BYTES_PER_WORD)) ? WRITE : RECV;
        end
        WRITE: begin
          wren      <= 1'b1;
          wraddress <= word_cnt;
          data      <= word;
          byte_cnt  <= '0;
          if (word_cnt == ADDR_W'(WORDS - 1)) begin
`ifdef UART_FRAME_LOADER_CSUM_EN
            state <= CHECK;
`else
            state <= DONE;
`endif
          end else begin
            word_cnt <= word_cnt + 1'b1;
            state    <= RECV;
          end
        end
`ifdef UART_FRAME_LOADER_CSUM_EN
        CHECK: begin
          if (byte_valid) begin
            csum_err <= (byte_data != sum);
            timer    <= '0;
            state    <= DONE;
          end else if (timer_hit) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
